// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
//
// Parameters:
//   DEPTH      number of entries; power of two, 2..16.
// Ports:
//   clk        clock; all state changes on its rising edge.
//   rst        asynchronous active-low reset.
//   in_valid   fetch offers {in_pc, in_instr} this cycle.
//   in_instr   instruction word from fetch.
//   in_pc      PC of in_instr.
//   in_ready   queue can accept an entry (not full, not halted).
//   out_valid  head entry is valid for decode.
//   out_instr  head instruction, 16'h0000 while empty.
//   out_pc     head PC, 16'h0000 while empty.
//   out_ready  decode consumes the head this cycle.
//   flush      discard all entries; overrides push and pop.
//   count      current occupancy, 0..DEPTH.
//   halted     a HALT (instr[15:11] == 0) has been queued.
//
// Build option: define IQ_HALT_DETECT_EN to compile in HALT detection.
// Without it, halted is tied low and in_ready depends only on occupancy.
module instr_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [15:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_instr,
  output logic [15:0]              out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [15:0]     instr_mem_q [DEPTH];
  logic [15:0]     pc_mem_q    [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halted_w;
  logic            push, pop;

  assign in_ready  = (count_q < DepthCnt) && !halted_w;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign halted    = halted_w;

  // Gate the head so an empty queue never exposes stale storage.
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 16'h0000;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 16'h0000;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PtrW bits wide, so increments wrap modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

`ifdef IQ_HALT_DETECT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (flush) begin
      halted_d = 1'b0;
    end else if (push && (in_instr[15:11] == 5'b00000)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted_w = halted_q;
`else
  assign halted_w = 1'b0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic [15:0] in_pc = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        halted;

  int checks = 0;
  int failures = 0;

  instr_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [15:0] pc, input logic [15:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state, checked with the clock running and rst held low.
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    check("rst_out_pc", 32'(out_pc), 32'h0);

    // Release reset between edges; first push taken on the next edge.
    @(negedge clk);
    rst = 1'b1;
    push1(16'h0000, 16'h1111);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_instr", 32'(out_instr), 32'h1111);
    check("first_count", 32'(count), 32'd1);
    pop1();
    check("first_pop_count", 32'(count), 32'd0);
    check("empty_out_instr", 32'(out_instr), 32'h0);
    check("empty_out_pc", 32'(out_pc), 32'h0);

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) push1(16'h0010 + 16'(i), 16'hA000 + 16'(i));
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push1(16'h0014, 16'hA004);
    check("full_reject_count", 32'(count), 32'd4);
    check("full_head_instr", 32'(out_instr), 32'hA000);
    for (int i = 0; i < 4; i++) begin
      check("drain_instr", 32'(out_instr), 32'hA000 + 32'(i));
      check("drain_pc", 32'(out_pc), 32'h0010 + 32'(i));
      pop1();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count 2.
    push1(16'h0020, 16'hB000);
    push1(16'h0021, 16'hB001);
    out_ready = 1'b1;
    push1(16'h0022, 16'hB002);
    out_ready = 1'b0;
    check("pushpop_count", 32'(count), 32'd2);
    check("pushpop_head", 32'(out_instr), 32'hB001);
    pop1();
    check("pushpop_second", 32'(out_instr), 32'hB002);
    pop1();
    check("pushpop_empty", 32'(count), 32'd0);

    // Ten entries through the queue, wrapping both pointers.
    for (int i = 0; i < 10; i++) begin
      push1(16'h0100 + 16'(i), 16'hC000 + 16'(i));
      check("wrap_instr", 32'(out_instr), 32'hC000 + 32'(i));
      check("wrap_pc", 32'(out_pc), 32'h0100 + 32'(i));
      pop1();
      check("wrap_count", 32'(count), 32'd0);
    end

    // Flush at count 3 with a same-cycle push.
    for (int i = 0; i < 3; i++) push1(16'h0200 + 16'(i), 16'hD000 + 16'(i));
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    push1(16'h0203, 16'hD003);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_instr", 32'(out_instr), 32'h0);
    push1(16'h0300, 16'hE000);
    check("postflush_head", 32'(out_instr), 32'hE000);
    check("postflush_count", 32'(count), 32'd1);

    // Asynchronous reset mid-operation, asserted between edges.
    push1(16'h0301, 16'hE001);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_instr", 32'(out_instr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    push1(16'h0400, 16'hF000);
    check("postrst_head", 32'(out_instr), 32'hF000);
    check("postrst_count", 32'(count), 32'd1);
    pop1();

`ifdef IQ_HALT_DETECT_EN
    push1(16'h0500, 16'h0000);
    check("halt_set", 32'(halted), 32'd1);
    check("halt_in_ready", 32'(in_ready), 32'd0);
    push1(16'h0501, 16'h2222);
    check("halt_reject_count", 32'(count), 32'd1);
    check("halt_head", 32'(out_instr), 32'h0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("halt_clear", 32'(halted), 32'd0);
    check("halt_clear_in_ready", 32'(in_ready), 32'd1);
`else
    push1(16'h0500, 16'h0000);
    check("nohalt_halted", 32'(halted), 32'd0);
    check("nohalt_in_ready", 32'(in_ready), 32'd1);
    push1(16'h0501, 16'h2222);
    check("nohalt_count", 32'(count), 32'd2);
    pop1();
    check("nohalt_second", 32'(out_instr), 32'h2222);
    pop1();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low; 0 resets immediately, independent of clk.
REQ-004 Port in_valid  input  1  fetch offers an instruction this cycle.
REQ-005 Port in_instr  input  16  instruction word from fetch.
REQ-006 Port in_pc  input  16  PC of in_instr.
REQ-007 Port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 Port out_valid  output  1  head entry is valid for decode.
REQ-009 Port out_instr  output  16  head instruction.
REQ-010 Port out_pc  output  16  head PC.
REQ-011 Port out_ready  input  1  decode consumes the head this cycle.
REQ-012 Port flush  input  1  discard all entries (branch redirect).
REQ-013 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 Port halted  output  1  HALT captured; see Configuration.

Function
REQ-015 Block SHALL be a DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
REQ-016 Push occurs when in_valid && in_ready at a rising edge; pop occurs when out_valid && out_ready at a rising edge.
REQ-017 in_ready SHALL be (count < DEPTH) && !halted, combinational from state only and independent of out_ready.
REQ-018 out_valid SHALL be (count != 0); out_instr/out_pc SHALL show the head entry with zero-cycle latency from storage.
REQ-019 Write and read pointers SHALL wrap modulo DEPTH; entries leave in push order.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and be legal at any non-full occupancy.
REQ-021 Push into an empty queue SHALL make the entry visible on out_* in the following cycle (one-cycle latency).
REQ-022 flush SHALL have priority over push and pop: next cycle count=0, pointers=0, halted=0, and any same-cycle push is dropped.
REQ-023 While empty, out_instr/out_pc SHALL be 16'h0000, never stale data.
REQ-024 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-025 On rst=0: count=0, pointers=0, out_valid=0, in_ready=1, halted=0, out_instr=16'h0000, out_pc=16'h0000.
REQ-026 Reset mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-027 First push SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-028 Macro IQ_HALT_DETECT_EN SHALL compile in HALT detection.
REQ-029 With it defined: a pushed entry with in_instr[15:11]==5'b00000 sets halted the next cycle; halted holds in_ready=0 until flush or reset; the HALT entry itself is queued and drains normally.
REQ-030 Without it: halted is tied 0 and in_ready depends only on occupancy.

Verification
REQ-031 Reset then push pc 0x0000/instr 0x1111 -> next cycle out_valid=1, out_instr=0x1111, count=1.
REQ-032 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; pops return entries in order.
REQ-033 count=2, push and pop in the same cycle -> count stays 2, head advances to the second entry.
REQ-034 Push 10 entries with alternating pops (pointer wrap) -> output sequence identical to input sequence, no loss or duplication.
REQ-035 count=3 with push in the same cycle as flush -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-036 IQ_HALT_DETECT_EN defined, push 0x0000 then offer 0x2222 -> halted=1, in_ready=0, 0x2222 not taken; flush -> halted=0, in_ready=1.
